dvb_s2_ts_packet_buffer: RTL and testbench

//  Upstream TS stage feeding dvb_s2_system_top. Accepts a byte stream already in the clk domain, aligns to 188-byte

---
 rtl/dvb_s2_ts_pkg.sv | 30 +++
 rtl/dvb_s2_ts_pkt_ram.sv | 38 +++
 rtl/dvb_s2_ts_packet_buffer.sv | 257 +++++++++++++++++++++++++
 tb/tb_dvb_s2_ts_packet_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dvb_s2_ts_pkg.sv
// Shared constants, FSM encodings and null-packet byte lookup for the TS packet buffer.
package dvb_s2_ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam logic [7:0] TS_LAST_IDX  = 8'(TS_PKT_LEN - 1);

    // Null packet header: sync, PID 0x1FFF, payload only, continuity counter 0
    localparam logic [7:0] NULL_HDR [0:3] = '{8'h47, 8'h1F, 8'hFF, 8'h10};

    typedef enum logic [1:0] {
        WR_HUNT,
        WR_CAPT,
        WR_DROP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SEND,
        RD_NULL
    } rd_state_e;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        if (idx < 8'd4) begin
            return NULL_HDR[idx[1:0]];
        end
        return 8'hFF;
    endfunction

endpackage

// File: rtl/dvb_s2_ts_pkt_ram.sv
// Simple dual-port packet RAM, one 256-byte page per packet slot, registered read port.
module dvb_s2_ts_pkt_ram
    import dvb_s2_ts_pkg::*;
#(
    parameter  int PKT_DEPTH = 4,
    localparam int ADDR_W    = $clog2(PKT_DEPTH) + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [PKT_DEPTH*256];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only moves on a read so the output byte holds between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dvb_s2_ts_packet_buffer.sv
// TS packet aligner/FIFO with null-packet insertion on underflow.
// Statistics counters are built only when DVB_S2_TS_STATS_EN is defined.
module dvb_s2_ts_packet_buffer
    import dvb_s2_ts_pkg::*;
#(
    parameter  int PKT_DEPTH = 4,
    parameter  int CNT_W     = 16,
    localparam int SLOT_W    = $clog2(PKT_DEPTH),
    localparam int LVL_W     = SLOT_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sync,
    input  logic             null_insert_en,
    input  logic             out_req,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sync,
    output logic [LVL_W-1:0] pkt_level,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] sync_err_cnt,
    output logic [CNT_W-1:0] null_cnt
);

    wr_state_e         wr_state_q, wr_state_d;
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
    logic [LVL_W-1:0]  pkt_level_q, pkt_level_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sync_q, out_sync_d;
    logic              from_ram_q, from_ram_d;
    logic [7:0]        null_data_q, null_data_d;

    logic              ram_we, ram_re;
    logic [SLOT_W+7:0] ram_waddr, ram_raddr;
    logic [7:0]        ram_rdata;
    logic              commit, release_pkt, fifo_full;
    logic              drop_ev, sync_err_ev, null_ev;

    assign fifo_full = (pkt_level_q == LVL_W'(PKT_DEPTH));

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_slot_d   = wr_slot_q;
        ram_we      = 1'b0;
        ram_waddr   = {wr_slot_q, wr_cnt_q};
        commit      = 1'b0;
        drop_ev     = 1'b0;
        sync_err_ev = 1'b0;
        unique case (wr_state_q)
            WR_HUNT: begin
                if (in_valid && in_sync) begin
                    if (in_data != TS_SYNC_BYTE) begin
                        sync_err_ev = 1'b1;
                    end else if (fifo_full) begin
                        drop_ev    = 1'b1;
                        wr_cnt_d   = 8'd1;
                        wr_state_d = WR_DROP;
                    end else begin
                        ram_we     = 1'b1;
                        ram_waddr  = {wr_slot_q, 8'd0};
                        wr_cnt_d   = 8'd1;
                        wr_state_d = WR_CAPT;
                    end
                end
            end
            WR_CAPT: begin
                if (in_valid) begin
                    // Early sync aborts the partial packet; a good sync restarts in the same slot
                    if (in_sync && wr_cnt_q != TS_LAST_IDX) begin
                        sync_err_ev = 1'b1;
                        if (in_data == TS_SYNC_BYTE) begin
                            ram_we    = 1'b1;
                            ram_waddr = {wr_slot_q, 8'd0};
                            wr_cnt_d  = 8'd1;
                        end else begin
                            wr_state_d = WR_HUNT;
                        end
                    end else begin
                        ram_we = 1'b1;
                        if (wr_cnt_q == TS_LAST_IDX) begin
                            commit     = 1'b1;
                            wr_slot_d  = wr_slot_q + SLOT_W'(1);
                            wr_state_d = WR_HUNT;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 8'd1;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (in_valid) begin
                    if (wr_cnt_q == TS_LAST_IDX) begin
                        wr_state_d = WR_HUNT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 8'd1;
                    end
                end
            end
            default: wr_state_d = WR_HUNT;
        endcase
    end

    // rd_cnt is 0 whenever the reader is idle, so one address expression serves all states
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_slot_d   = rd_slot_q;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        from_ram_d  = from_ram_q;
        null_data_d = null_data_q;
        ram_re      = 1'b0;
        ram_raddr   = {rd_slot_q, rd_cnt_q};
        release_pkt = 1'b0;
        null_ev     = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (out_req) begin
                    if (pkt_level_q != '0) begin
                        ram_re      = 1'b1;
                        out_valid_d = 1'b1;
                        out_sync_d  = 1'b1;
                        from_ram_d  = 1'b1;
                        rd_cnt_d    = 8'd1;
                        rd_state_d  = RD_SEND;
                    end else if (null_insert_en) begin
                        null_ev     = 1'b1;
                        out_valid_d = 1'b1;
                        out_sync_d  = 1'b1;
                        from_ram_d  = 1'b0;
                        null_data_d = TS_SYNC_BYTE;
                        rd_cnt_d    = 8'd1;
                        rd_state_d  = RD_NULL;
                    end
                end
            end
            RD_SEND, RD_NULL: begin
                if (out_req) begin
                    out_valid_d = 1'b1;
                    if (rd_state_q == RD_SEND) begin
                        ram_re = 1'b1;
                    end else begin
                        null_data_d = null_byte(rd_cnt_q);
                    end
                    if (rd_cnt_q == TS_LAST_IDX) begin
                        rd_cnt_d   = 8'd0;
                        rd_state_d = RD_IDLE;
                        if (rd_state_q == RD_SEND) begin
                            release_pkt = 1'b1;
                            rd_slot_d   = rd_slot_q + SLOT_W'(1);
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + 8'd1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign pkt_level_d = pkt_level_q + LVL_W'(commit) - LVL_W'(release_pkt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q  <= WR_HUNT;
            wr_cnt_q    <= '0;
            wr_slot_q   <= '0;
            rd_state_q  <= RD_IDLE;
            rd_cnt_q    <= '0;
            rd_slot_q   <= '0;
            pkt_level_q <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
            from_ram_q  <= 1'b0;
            null_data_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_slot_q   <= wr_slot_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_slot_q   <= rd_slot_d;
            pkt_level_q <= pkt_level_d;
            out_valid_q <= out_valid_d;
            out_sync_q  <= out_sync_d;
            from_ram_q  <= from_ram_d;
            null_data_q <= null_data_d;
        end
    end

    dvb_s2_ts_pkt_ram #(.PKT_DEPTH(PKT_DEPTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (in_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign out_valid = out_valid_q;
    assign out_sync  = out_sync_q;
    assign out_data  = from_ram_q ? ram_rdata : null_data_q;
    assign pkt_level = pkt_level_q;

`ifdef DVB_S2_TS_STATS_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] sync_err_cnt_q, sync_err_cnt_d;
    logic [CNT_W-1:0] null_cnt_q, null_cnt_d;

    always_comb begin
        drop_cnt_d     = drop_cnt_q;
        sync_err_cnt_d = sync_err_cnt_q;
        null_cnt_d     = null_cnt_q;
        if (drop_ev && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (sync_err_ev && !(&sync_err_cnt_q)) begin
            sync_err_cnt_d = sync_err_cnt_q + CNT_W'(1);
        end
        if (null_ev && !(&null_cnt_q)) begin
            null_cnt_d = null_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q     <= '0;
            sync_err_cnt_q <= '0;
            null_cnt_q     <= '0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            sync_err_cnt_q <= sync_err_cnt_d;
            null_cnt_q     <= null_cnt_d;
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign sync_err_cnt = sync_err_cnt_q;
    assign null_cnt     = null_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = drop_ev | sync_err_ev | null_ev;
    assign drop_cnt     = '0;
    assign sync_err_cnt = '0;
    assign null_cnt     = '0;
`endif

endmodule

// File: tb/tb_dvb_s2_ts_packet_buffer.sv
// Scoreboard bench for dvb_s2_ts_packet_buffer: directed packets in, expected bytes queued, monitor compares.
`timescale 1ns/1ps
module tb_dvb_s2_ts_packet_buffer;

    localparam int PKT_DEPTH = 4;
    localparam int CNT_W     = 16;
`ifdef DVB_S2_TS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_sync = 1'b0;
    logic             null_insert_en = 1'b0;
    logic             out_req = 1'b0;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sync;
    logic [2:0]       pkt_level;
    logic [CNT_W-1:0] drop_cnt, sync_err_cnt, null_cnt;

    always #5 clk = ~clk;

    dvb_s2_ts_packet_buffer #(.PKT_DEPTH(PKT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_sync        (in_sync),
        .null_insert_en (null_insert_en),
        .out_req        (out_req),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sync       (out_sync),
        .pkt_level      (pkt_level),
        .drop_cnt       (drop_cnt),
        .sync_err_cnt   (sync_err_cnt),
        .null_cnt       (null_cnt)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    int         valid_seen = 0;
    int         lvl_max = 0;
    logic [8:0] exp_q [$];

    function automatic logic [7:0] pkt_byte(input int tag, input int idx);
        if (idx == 0) return 8'h47;
        return 8'((idx + tag) % 256);
    endfunction

    function automatic logic [7:0] null_ref(input int idx);
        case (idx)
            0: return 8'h47;
            1: return 8'h1F;
            2: return 8'hFF;
            3: return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int exp_cnt(input int n);
        return STATS ? n : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s, input logic r);
        in_valid = v;
        in_data  = d;
        in_sync  = s;
        out_req  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic write_packet(input int tag);
        for (int i = 0; i < 188; i++) applyStimulus(1'b1, pkt_byte(tag, i), i == 0, 1'b0);
    endtask

    task automatic expect_packet(input int tag);
        for (int i = 0; i < 188; i++) exp_q.push_back({i == 0, pkt_byte(tag, i)});
    endtask

    task automatic expect_null();
        for (int i = 0; i < 188; i++) exp_q.push_back({i == 0, null_ref(i)});
    endtask

    task automatic read_bytes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            repeat (gap) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (int'(pkt_level) > lvl_max) lvl_max = int'(pkt_level);
        if (out_valid === 1'b1) begin
            valid_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_byte: got sync=%0b data=%h, expected no output", out_sync, out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_sync, out_data} !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL out_byte: got sync=%0b data=%h, expected sync=%0b data=%h",
                             out_sync, out_data, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        // Test 1: reset state, three clean packets read back with strobe gaps
        do_reset();
        checkOutput("reset_outputs", 64'({out_valid, out_sync, out_data, pkt_level, drop_cnt, sync_err_cnt, null_cnt}), 64'd0);
        for (int p = 0; p < 3; p++) write_packet(0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_level3", 64'(pkt_level), 64'd3);
        for (int p = 0; p < 3; p++) expect_packet(0);
        read_bytes(564, 1);
        checkOutput("t1_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("t1_level0", 64'(pkt_level), 64'd0);
        checkOutput("t1_null_cnt", 64'(null_cnt), 64'd0);

        // Test 2: underflow with and without null insertion
        do_reset();
        null_insert_en = 1'b1;
        expect_null();
        expect_null();
        read_bytes(376, 0);
        checkOutput("t2_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("t2_null_cnt", 64'(null_cnt), 64'(exp_cnt(2)));
        null_insert_en = 1'b0;
        valid_seen = 0;
        read_bytes(50, 0);
        checkOutput("t2_no_valid", 64'(valid_seen), 64'd0);

        // Test 3: early sync at byte 100 restarts the packet in the same slot
        do_reset();
        lvl_max = 0;
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, pkt_byte(2, i), i == 0, 1'b0);
        write_packet(5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t3_sync_err", 64'(sync_err_cnt), 64'(exp_cnt(1)));
        checkOutput("t3_level1", 64'(pkt_level), 64'd1);
        expect_packet(5);
        read_bytes(188, 0);
        checkOutput("t3_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("t3_level_peak", 64'(lvl_max), 64'd1);

        // Test 4: overfill drops packets 5 and 6, 1..4 come out in order
        do_reset();
        for (int p = 1; p <= 6; p++) write_packet(p);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t4_level_full", 64'(pkt_level), 64'd4);
        checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'(exp_cnt(2)));
        for (int p = 1; p <= 4; p++) expect_packet(p);
        read_bytes(752, 0);
        checkOutput("t4_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("t4_level0", 64'(pkt_level), 64'd0);

        // Test 5: commit and idle request in the same cycle -> null first, then the packet
        do_reset();
        null_insert_en = 1'b1;
        for (int i = 0; i < 563; i++) begin
            if (i >= 187) begin
                int k;
                k = i - 187;
                if (k < 188) exp_q.push_back({k == 0, null_ref(k)});
                else exp_q.push_back({k == 188, pkt_byte(9, k - 188)});
            end
            applyStimulus(i <= 187, pkt_byte(9, i), i == 0, i >= 187);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("t5_null_cnt", 64'(null_cnt), 64'(exp_cnt(1)));
        checkOutput("t5_level0", 64'(pkt_level), 64'd0);
        null_insert_en = 1'b0;

        // Test 6: reset during input byte 90 / output byte 50, then a clean packet
        do_reset();
        write_packet(3);
        for (int i = 0; i < 90; i++) begin
            if (i >= 40) exp_q.push_back({i == 40, pkt_byte(3, i - 40)});
            applyStimulus(1'b1, pkt_byte(4, i), i == 0, i >= 40);
        end
        rst_n = 1'b0;
        repeat (3) applyStimulus(1'b1, pkt_byte(4, 90), 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t6_reset_outputs", 64'({out_valid, out_sync, out_data, pkt_level, drop_cnt, sync_err_cnt, null_cnt}), 64'd0);
        checkOutput("t6_partial_drain", 64'(exp_q.size()), 64'd0);
        write_packet(7);
        expect_packet(7);
        read_bytes(188, 0);
        checkOutput("t6_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
